// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - debounced three-press operand/opcode capture with valid/ack issue
// Two bouncy active-low keys step operand A, operand B and opcode capture, then offer the op downstream.
module alu_operand_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [15:0] sw_data,
   input  logic        sw_sext,
   input  logic        key_adv_n,
   input  logic        key_clr_n,
   input  logic        op_ack,
   output logic [31:0] port_a,
   output logic [31:0] port_b,
   output logic [3:0]  aluop,
   output logic        op_valid,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      ISSUE   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit 0 is the advance key, bit 1 the clear key.
   logic [1:0]       keys;
   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       deb;
   logic [1:0]       press;
   logic [CNT_W-1:0] cnt [2];

   assign keys = {key_clr_n, key_adv_n};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sync1  <= 2'b11;
         sync2  <= 2'b11;
         deb    <= 2'b11;
         press  <= 2'b00;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= keys;
         sync2 <= sync1;
         for (int k = 0; k < 2; k++) begin
            press[k] <= 1'b0;
            if (sync2[k] == deb[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == CNT_LAST) begin
               cnt[k] <= '0;
               deb[k] <= sync2[k];
               // Only a settled 1->0 change is an event; a settled release is silent.
               press[k] <= ~sync2[k];
            end else begin
               cnt[k] <= cnt[k] + CNT_W'(1);
            end
         end
      end
   end

   logic        adv_press;
   logic        clr_press;
   logic [31:0] operand;

   assign adv_press = press[0];
   assign clr_press = press[1];
   assign operand   = {sw_sext ? 16'hffff : 16'h0000, sw_data};

   state_t      state;
   state_t      state_nx;
   logic [31:0] a_nx;
   logic [31:0] b_nx;
   logic [3:0]  op_nx;
   logic        valid_nx;

   always_comb begin
      state_nx = state;
      a_nx     = port_a;
      b_nx     = port_b;
      op_nx    = aluop;
      valid_nx = op_valid;
      if (clr_press) begin
         state_nx = LOAD_A;
         a_nx     = '0;
         b_nx     = '0;
         op_nx    = '0;
         valid_nx = 1'b0;
      end else begin
         case (state)
            LOAD_A: begin
               if (adv_press) begin
                  a_nx     = operand;
                  state_nx = LOAD_B;
               end
            end
            LOAD_B: begin
               if (adv_press) begin
                  b_nx     = operand;
                  state_nx = LOAD_OP;
               end
            end
            LOAD_OP: begin
               if (adv_press) begin
                  op_nx    = sw_data[3:0];
                  valid_nx = 1'b1;
                  state_nx = ISSUE;
               end
            end
            ISSUE: begin
               // Advance presses here are dropped; operands stay visible after ack.
               if (op_ack) begin
                  valid_nx = 1'b0;
                  state_nx = LOAD_A;
               end
            end
            default: state_nx = LOAD_A;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= LOAD_A;
         port_a   <= '0;
         port_b   <= '0;
         aluop    <= '0;
         op_valid <= 1'b0;
      end else begin
         state    <= state_nx;
         port_a   <= a_nx;
         port_b   <= b_nx;
         aluop    <= op_nx;
         op_valid <= valid_nx;
      end
   end

   assign state_o = state;

endmodule
